// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding,
// counter width and a constant-evaluable ceil(log2) helper.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int unsigned CNT_W = 4;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of req_i scanning
// last_i+1, last_i+2, ... modulo NREQ (last_i itself is visited last).
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic            found_o,
    output logic [IDW-1:0]  index_o
);

    always_comb begin
        int unsigned    idx;
        logic [IDW-1:0] sel;
        found_o = 1'b0;
        index_o = '0;
        idx     = 0;
        sel     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_i) + k) % NREQ;
            sel = IDW'(idx);
            if (!found_o && req_i[sel]) begin
                found_o = 1'b1;
                index_o = sel;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the async FIFO (wclk domain). A grant
// owns the port for a whole packet, up to MAX_BURST beats, or until it idles.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned NREQ      = 4,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned IDLE_TO   = 8
) (
    input  logic                   wclk,
    input  logic                   wrst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DSIZE-1:0]  req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   wfull,
    output logic [DSIZE-1:0]       wdata,
    output logic                   winc,
    output logic [clog2(NREQ)-1:0] grant_id,
    output logic                   busy
);

    localparam int unsigned IDW = clog2(NREQ);

    arb_state_e       state_q, state_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] idle_q, idle_d;

    logic [DSIZE-1:0] lane_data [NREQ];
    logic [NREQ-1:0]  owner_oh;
    logic [NREQ-1:0]  pick_req;
    logic [IDW-1:0]   pick_from;
    logic [IDW-1:0]   pick_idx;
    logic             pick_found;
    logic             in_burst;
    logic             owner_valid;
    logic             accept;
    logic             pkt_done;
    logic             burst_end;

    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign lane_data[g] = req_data[g*DSIZE +: DSIZE];
    end

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    assign in_burst    = (state_q == BURST);
    assign owner_valid = req_valid[owner_q];
    assign accept      = in_burst && owner_valid && !wfull && !wrst;
    assign pkt_done    = accept && req_last[owner_q];
    assign burst_end   = in_burst &&
                         ((accept && (req_last[owner_q] || beat_q == CNT_W'(MAX_BURST - 1))) ||
                          (!owner_valid && idle_q == CNT_W'(IDLE_TO - 1)));

    // One selector serves both paths: from last_owner in IDLE, from the
    // current owner at burst end. A finished packet's own valid is already
    // consumed, so the owner is masked out of the rescan in that case only.
    assign pick_from = in_burst ? owner_q : last_q;
    assign pick_req  = pkt_done ? (req_valid & ~owner_oh) : req_valid;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i   (pick_req),
        .last_i  (pick_from),
        .found_o (pick_found),
        .index_o (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;
        idle_d  = idle_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BURST;
                    owner_d = pick_idx;
                    beat_d  = '0;
                    idle_d  = '0;
                end
            end
            BURST: begin
                if (accept) begin
                    beat_d = beat_q + 1'b1;
                end
                idle_d = owner_valid ? '0 : idle_q + 1'b1;
                if (burst_end) begin
                    last_d = owner_q;
                    beat_d = '0;
                    idle_d = '0;
                    if (pick_found) begin
                        owner_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDW'(NREQ - 1);
            beat_q  <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            idle_q  <= idle_d;
        end
    end

    assign busy      = in_burst;
    assign grant_id  = owner_q;
    assign winc      = accept;
    assign req_ready = accept ? owner_oh : '0;
    assign wdata     = in_burst ? lane_data[owner_q] : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter against a queue-based
// ownership model; each requester's packets live in a per-requester queue.
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DSIZE     = 8;
    localparam int MAX_BURST = 4;
    localparam int IDLE_TO   = 8;

    logic                  wclk = 1'b0;
    logic                  wrst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic [DSIZE-1:0]      wdata;
    logic                  winc;
    logic [1:0]            grant_id;
    logic                  busy;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(
        .DSIZE     (DSIZE),
        .NREQ      (NREQ),
        .MAX_BURST (MAX_BURST),
        .IDLE_TO   (IDLE_TO)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wfull     (wfull),
        .wdata     (wdata),
        .winc      (winc),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [8:0]      pq [NREQ][$];   // {last, data} per pending beat
    logic [NREQ-1:0] en;
    logic            rst_cmd;
    logic            full_cmd;

    bit m_busy;
    int m_owner, m_last, m_beats, m_idle;

    logic s_winc, s_busy;
    int   s_wdata, s_gid, s_ready;

    int log_id[$];
    int log_dat[$];
    int log_cyc[$];

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int rr(int from, logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (from + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic push_pkt(int r, int n, int base, bit lst);
        for (int k = 0; k < n; k++) begin
            pq[r].push_back({(lst && k == n - 1), 8'(base + k)});
        end
    endtask

    task automatic drive();
        logic [8:0] h;
        wrst  = rst_cmd;
        wfull = full_cmd;
        for (int r = 0; r < NREQ; r++) begin
            if (en[r] && pq[r].size() > 0) begin
                h = pq[r][0];
                req_valid[r]         = 1'b1;
                req_data[r*8 +: 8]   = h[7:0];
                req_last[r]          = h[8];
            end else begin
                req_valid[r]         = 1'b0;
                req_data[r*8 +: 8]   = 8'($urandom);
                req_last[r]          = 1'($urandom);
            end
        end
    endtask

    task automatic model_cycle();
        logic [NREQ-1:0] rv, cand;
        logic [7:0]      lane;
        bit              acc, done_pkt, done_end;
        int              e_wdata, e_ready;
        rv      = req_valid;
        lane    = 8'(req_data >> (m_owner * 8));
        acc     = m_busy && rv[m_owner] && !wfull && !wrst;
        e_wdata = m_busy ? int'(lane) : 0;
        e_ready = acc ? (1 << m_owner) : 0;

        check("winc", int'(winc), int'(acc));
        check("req_ready", int'(req_ready), e_ready);
        check("wdata", int'(wdata), e_wdata);
        check("grant_id", int'(grant_id), m_owner);
        check("busy", int'(busy), int'(m_busy));

        s_winc  = winc;
        s_busy  = busy;
        s_wdata = int'(wdata);
        s_gid   = int'(grant_id);
        s_ready = int'(req_ready);
        if (winc) begin
            log_id.push_back(int'(grant_id));
            log_dat.push_back(int'(wdata));
            log_cyc.push_back(cyc);
        end
        if (acc) void'(pq[m_owner].pop_front());

        if (wrst) begin
            m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_beats = 0; m_idle = 0;
        end else if (!m_busy) begin
            if (rv != 0) begin
                m_owner = rr(m_last, rv);
                m_busy  = 1; m_beats = 0; m_idle = 0;
            end
        end else begin
            done_pkt = acc && req_last[m_owner];
            if (acc) m_beats++;
            m_idle   = rv[m_owner] ? 0 : m_idle + 1;
            done_end = done_pkt || (acc && m_beats == MAX_BURST) || (m_idle == IDLE_TO);
            if (done_end) begin
                m_last = m_owner; m_beats = 0; m_idle = 0;
                cand = rv;
                if (done_pkt) cand[m_owner] = 1'b0;
                if (cand != 0) m_owner = rr(m_owner, cand);
                else m_busy = 0;
            end
        end
    endtask

    task automatic step();
        drive();
        @(negedge wclk);
        model_cycle();
        @(posedge wclk);
        #1;
        cyc++;
    endtask

    task automatic drain(int maxc);
        int n, pend;
        en = '1; full_cmd = 1'b0; rst_cmd = 1'b0; n = 0;
        forever begin
            pend = 0;
            for (int r = 0; r < NREQ; r++) pend += pq[r].size();
            if ((pend == 0 && !m_busy) || n >= maxc) break;
            step();
            n++;
        end
        check("drain_done", int'(pend == 0 && !m_busy), 1);
    endtask

    task automatic clear_log();
        log_id.delete(); log_dat.delete(); log_cyc.delete();
    endtask

    task automatic expect_log(string nm, input int eid[8], input int edat[8], input int n);
        check({nm, "_len"}, log_dat.size(), n);
        for (int i = 0; i < n && i < log_dat.size(); i++) begin
            check({nm, "_id"}, log_id[i], eid[i]);
            check({nm, "_dat"}, log_dat[i], edat[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        wrst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; wfull = 1'b0;
        rst_cmd = 1'b1; full_cmd = 1'b0; en = '1;
        m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_beats = 0; m_idle = 0;
        @(posedge wclk);
        #1;

        // Reset held with every requester valid
        for (int r = 0; r < NREQ; r++) push_pkt(r, 1, 'h10 + r, 1'b1);
        repeat (3) begin
            step();
            check("t1_rst_winc", int'(s_winc), 0);
            check("t1_rst_ready", s_ready, 0);
            check("t1_rst_busy", int'(s_busy), 0);
            check("t1_rst_gid", s_gid, 0);
        end
        rst_cmd = 1'b0;
        clear_log();
        step();
        check("t1_idle_busy", int'(s_busy), 0);
        step();
        check("t1_first_gid", s_gid, 0);
        check("t1_first_winc", int'(s_winc), 1);
        check("t1_first_dat", s_wdata, 'h10);
        drain(100);

        // Single 3-beat packet
        clear_log();
        push_pkt(0, 3, 'h01, 1'b1);
        step();
        check("t2_latency_winc", int'(s_winc), 0);
        repeat (3) step();
        step();
        check("t2_back_idle", int'(s_busy), 0);
        expect_log("t2", '{0, 0, 0, 0, 0, 0, 0, 0}, '{'h01, 'h02, 'h03, 0, 0, 0, 0, 0}, 3);
        if (log_cyc.size() == 3) check("t2_contig", log_cyc[2] - log_cyc[0], 2);

        // Round-robin between two packets, no bubble
        clear_log();
        push_pkt(1, 2, 'hA1, 1'b1);
        push_pkt(3, 2, 'hB1, 1'b1);
        drain(100);
        expect_log("t3", '{1, 1, 3, 3, 0, 0, 0, 0}, '{'hA1, 'hA2, 'hB1, 'hB2, 0, 0, 0, 0}, 4);
        if (log_cyc.size() == 4) check("t3_nogap", log_cyc[3] - log_cyc[0], 3);

        // MAX_BURST forced rotation
        clear_log();
        en = 4'b0100;
        push_pkt(2, 6, 'h21, 1'b0);
        push_pkt(0, 2, 'h01, 1'b1);
        step();
        drain(200);
        expect_log("t4", '{2, 2, 2, 2, 0, 0, 2, 2},
                   '{'h21, 'h22, 'h23, 'h24, 'h01, 'h02, 'h25, 'h26}, 8);

        // Backpressure mid-burst
        clear_log();
        push_pkt(1, 4, 'h51, 1'b1);
        repeat (3) step();
        full_cmd = 1'b1;
        repeat (5) begin
            step();
            check("t5_stall_winc", int'(s_winc), 0);
            check("t5_stall_busy", int'(s_busy), 1);
            check("t5_stall_dat", s_wdata, 'h53);
        end
        drain(100);
        expect_log("t5", '{1, 1, 1, 1, 0, 0, 0, 0}, '{'h51, 'h52, 'h53, 'h54, 0, 0, 0, 0}, 4);

        // Owner idle timeout hands over to the next requester
        clear_log();
        en = 4'b0001;
        push_pkt(0, 2, 'h61, 1'b0);
        push_pkt(3, 1, 'h63, 1'b1);
        step();
        step();
        en = 4'b1000;
        repeat (IDLE_TO) begin
            step();
            check("t6_hold_gid", s_gid, 0);
            check("t6_hold_busy", int'(s_busy), 1);
        end
        step();
        check("t6_handover_gid", s_gid, 3);
        check("t6_handover_winc", int'(s_winc), 1);
        check("t6_handover_dat", s_wdata, 'h63);
        drain(100);
        expect_log("t6", '{0, 3, 0, 0, 0, 0, 0, 0}, '{'h61, 'h63, 'h62, 0, 0, 0, 0, 0}, 3);

        // Reset mid-burst
        clear_log();
        push_pkt(1, 4, 'h71, 1'b1);
        repeat (3) step();
        rst_cmd = 1'b1;
        step();
        check("t7_rst_winc", int'(s_winc), 0);
        check("t7_rst_ready", s_ready, 0);
        rst_cmd = 1'b0;
        step();
        check("t7_rst_idle", int'(s_busy), 0);
        drain(100);
        expect_log("t7", '{1, 1, 1, 1, 0, 0, 0, 0}, '{'h71, 'h72, 'h73, 'h74, 0, 0, 0, 0}, 4);

        // Random traffic
        repeat (3000) begin
            for (int r = 0; r < NREQ; r++) begin
                if ($urandom_range(0, 9) == 0 && pq[r].size() < 10)
                    push_pkt(r, $urandom_range(1, 6), $urandom_range(0, 255),
                             $urandom_range(0, 4) != 0);
                en[r] = ($urandom_range(0, 99) < 85);
            end
            if ($urandom_range(0, 9) == 0) full_cmd = ~full_cmd;
            rst_cmd = ($urandom_range(0, 399) == 0);
            step();
        end
        drain(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
